// File: rtl/hdr_pkg.sv
// Shared definitions for the HDR frame writer.
//  - frame geometry (words per frame, pixels per 128-bit word)
//  - RGB565 field widths of a packed pixel
//  - write-path FSM state encoding
package hdr_pkg;

  localparam int unsigned FRAME_WORDS     = 38400;
  localparam int unsigned PIXELS_PER_WORD = 8;
  localparam int unsigned RGB_R_W         = 5;
  localparam int unsigned RGB_G_W         = 6;
  localparam int unsigned RGB_B_W         = 5;
  localparam int unsigned PIXEL_W         = RGB_R_W + RGB_G_W + RGB_B_W;
  localparam int unsigned WORD_W          = PIXELS_PER_WORD * PIXEL_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_BURST     = 2'd2,
    ST_FRAME_END = 2'd3
  } wr_state_t;

endpackage

// File: rtl/hdr_wr_fifo.sv
// Synchronous FIFO buffering tone-mapped words ahead of the SDRAM writer.
//  clk, rst : clock, synchronous active-high reset (empties the FIFO)
//  push     : write din; accepted when not full, or when a pop occurs
//             in the same cycle
//  pop      : advance the read pointer (ignored when empty)
//  din/dout : write data / head-of-FIFO data (combinational read)
//  count    : number of stored words (0..DEPTH)
//  full     : count == DEPTH
//  empty    : count == 0
module hdr_wr_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hdr_frame_writer.sv
// HDR frame writer: buffers packed RGB565 words from the tone mapper and
// writes them to the SDRAM frame buffer in fixed-length bursts, alternating
// between two frame buffers so the display always scans a complete frame.
//  clk, rst       : clock, synchronous active-high reset
//  hdr_data       : 128-bit word of 8 packed pixels
//  hdr_data_valid : hdr_data strobe
//  wr_req/wr_ack  : burst request handshake; beats start the cycle after wr_ack
//  wr_addr        : burst start word address, stable while wr_req=1
//  wr_data        : registered write beat, qualified by wr_data_valid
//  frame_written  : one-cycle pulse after the last burst of a frame
//  buf_sel        : buffer being written (display reads ~buf_sel)
//  overflow       : sticky, a word was dropped on a full FIFO
// Optional build macro HDR_FRAME_WRITER_DROP_CNT_EN adds drop_cnt[15:0],
// a saturating dropped-word count cleared on reset and on frame_written.
module hdr_frame_writer
  import hdr_pkg::*;
#(
  parameter int unsigned         FIFO_DEPTH  = 32,
  parameter int unsigned         BURST_LEN   = 8,
  parameter int unsigned         FRAME_WORDS = hdr_pkg::FRAME_WORDS,
  parameter int unsigned         ADDR_W      = 22,
  parameter logic [ADDR_W-1:0]   BUF0_BASE   = 22'h000000,
  parameter logic [ADDR_W-1:0]   BUF1_BASE   = 22'h010000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  hdr_data,
  input  logic               hdr_data_valid,
  output logic               wr_req,
  input  logic               wr_ack,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [WORD_W-1:0]  wr_data,
  output logic               wr_data_valid,
  output logic               frame_written,
  output logic               buf_sel,
  output logic               overflow
`ifdef HDR_FRAME_WRITER_DROP_CNT_EN
  ,
  output logic [15:0]        drop_cnt
`endif
);

  localparam int unsigned CNT_W  = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

  wr_state_t          state;
  wr_state_t          state_nxt;
  logic [BEAT_W-1:0]  beat;
  logic [CNT_W-1:0]   word_cnt;
  logic [CNT_W-1:0]   word_cnt_inc;
  logic               last_beat;

  logic [WORD_W-1:0]  fifo_dout;
  logic [FCNT_W-1:0]  fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               drop;

  assign word_cnt_inc = word_cnt + CNT_W'(BURST_LEN);
  assign last_beat    = (beat == BEAT_W'(BURST_LEN - 1));

  // wr_data is registered, so the head is popped one cycle ahead of the
  // beat it appears on: on the wr_ack cycle and on every BURST cycle but
  // the last. That yields exactly BURST_LEN pops and beats.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_REQ && wr_ack) ||
                     (state == ST_BURST && !last_beat));

  assign drop = hdr_data_valid && fifo_full && !fifo_pop;

  hdr_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hdr_data_valid),
    .pop   (fifo_pop),
    .din   (hdr_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt     = state;
    wr_req        = 1'b0;
    frame_written = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fifo_count >= FCNT_W'(BURST_LEN)) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        wr_req = 1'b1;
        if (wr_ack) begin
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (last_beat) begin
          state_nxt = (word_cnt_inc == CNT_W'(FRAME_WORDS)) ? ST_FRAME_END : ST_IDLE;
        end
      end
      ST_FRAME_END: begin
        frame_written = 1'b1;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      beat          <= '0;
      word_cnt      <= '0;
      buf_sel       <= 1'b0;
      wr_addr       <= BUF0_BASE;
      wr_data       <= '0;
      wr_data_valid <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state         <= state_nxt;
      wr_data_valid <= fifo_pop;
      if (fifo_pop) begin
        wr_data <= fifo_dout;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (state == ST_IDLE && state_nxt == ST_REQ) begin
        wr_addr <= (buf_sel ? BUF1_BASE : BUF0_BASE) + ADDR_W'(word_cnt);
      end
      if (state == ST_REQ) begin
        beat <= '0;
      end else if (state == ST_BURST) begin
        beat <= beat + BEAT_W'(1);
      end
      if (state == ST_BURST && last_beat) begin
        word_cnt <= word_cnt_inc;
      end
      if (state == ST_FRAME_END) begin
        word_cnt <= '0;
        buf_sel  <= ~buf_sel;
      end
    end
  end

`ifdef HDR_FRAME_WRITER_DROP_CNT_EN
  // The frame_written clear wins over a drop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || frame_written) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hdr_frame_writer.sv
module tb_hdr_frame_writer;

  localparam int unsigned FRAME_W = 38400;
  localparam int unsigned BL      = 8;
  localparam logic [21:0] BUF0    = 22'h000000;
  localparam logic [21:0] BUF1    = 22'h010000;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] hdr_data;
  logic         hdr_data_valid;
  logic         wr_req;
  logic         wr_ack;
  logic [21:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_data_valid;
  logic         frame_written;
  logic         buf_sel;
  logic         overflow;
`ifdef HDR_FRAME_WRITER_DROP_CNT_EN
  logic [15:0]  drop_cnt;
`endif

  always #5 clk = ~clk;

  hdr_frame_writer dut (
    .clk            (clk),
    .rst            (rst),
    .hdr_data       (hdr_data),
    .hdr_data_valid (hdr_data_valid),
    .wr_req         (wr_req),
    .wr_ack         (wr_ack),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_data_valid  (wr_data_valid),
    .frame_written  (frame_written),
    .buf_sel        (buf_sel),
    .overflow       (overflow)
`ifdef HDR_FRAME_WRITER_DROP_CNT_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  int unsigned  total = 0;
  int unsigned  bad   = 0;

  // Reference model: words accepted but not yet written, and the frame
  // position / buffer the next written word belongs to.
  logic [127:0] exp_q [$];
  int           pushed     = 0;
  int           beats_seen = 0;
  int unsigned  m_word     = 0;
  logic         m_buf      = 1'b0;
  bit           fw_pending = 1'b0;
  int unsigned  fw_count   = 0;
  int unsigned  run_len    = 0;
  logic         prev_req   = 1'b0;
  bit           mon_en     = 1'b0;

  bit           ack_en  = 1'b1;
  int unsigned  ack_min = 0;
  int unsigned  ack_max = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Memory-controller stand-in: acknowledges a pending request after a
  // random delay.
  initial begin
    int unsigned d;
    wr_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      wr_ack = 1'b0;
      if (wr_req && ack_en) begin
        d = $urandom_range(ack_max, ack_min);
        repeat (d) begin
          @(posedge clk); #1;
        end
        if (wr_req && ack_en) wr_ack = 1'b1;
      end
    end
  end

  // Monitor: compares every beat and request against the model.
  initial begin
    logic [21:0] ea;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        run_len    = 0;
        prev_req   = 1'b0;
        fw_pending = 1'b0;
      end else begin
        if (fw_pending || frame_written) begin
          check("frame_written", 128'(frame_written), 128'(fw_pending));
          if (frame_written) fw_count++;
        end
        fw_pending = 1'b0;
        if (wr_req && !prev_req) begin
          ea = (m_buf ? BUF1 : BUF0) + 22'(m_word);
          check("wr_addr", 128'(wr_addr), 128'(ea));
          check("buf_sel", 128'(buf_sel), 128'(m_buf));
        end
        prev_req = wr_req;
        if (wr_data_valid) begin
          beats_seen++;
          run_len++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected: got %0h want none", wr_data);
          end else begin
            check("beat_data", wr_data, exp_q.pop_front());
          end
          m_word++;
          if (m_word == FRAME_W) begin
            m_word     = 0;
            m_buf      = ~m_buf;
            fw_pending = 1'b1;
          end
        end else if (run_len != 0) begin
          check("burst_len", 128'(run_len), 128'(BL));
          run_len = 0;
        end
      end
    end
  end

  function automatic logic [127:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input logic [127:0] d, input bit keep);
    hdr_data       = d;
    hdr_data_valid = 1'b1;
    if (keep) begin
      exp_q.push_back(d);
      pushed++;
    end
    @(posedge clk); #1;
    hdr_data_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int unsigned limit);
    for (int unsigned i = 0; i < limit && exp_q.size() != 0; i++) idle(1);
    check(name, 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    idle(3);
  endtask

  // Random-rate stream, throttled so the FIFO can never overflow.
  task automatic stream(input int unsigned n, input int unsigned prob);
    int unsigned sent = 0;
    int unsigned cyc  = 0;
    while (sent < n) begin
      if (cyc > n * 4 + 1000) begin
        total++;
        bad++;
        $display("FAIL stream_timeout: got %0d want %0d", sent, n);
        break;
      end
      if ($urandom_range(7, 0) < prob && (pushed - beats_seen) <= 20) begin
        push(rand_word(), 1'b1);
        sent++;
      end else begin
        idle(1);
      end
      cyc++;
    end
  endtask

  initial begin
    bit seen;
    rst            = 1'b1;
    hdr_data       = '0;
    hdr_data_valid = 1'b0;
    idle(2);

    check("rst_wr_req",        128'(wr_req),        128'(0));
    check("rst_wr_data_valid", 128'(wr_data_valid), 128'(0));
    check("rst_frame_written", 128'(frame_written), 128'(0));
    check("rst_buf_sel",       128'(buf_sel),       128'(0));
    check("rst_overflow",      128'(overflow),      128'(0));
    check("rst_wr_addr",       128'(wr_addr),       128'(BUF0));
    check("rst_wr_data",       wr_data,             128'(0));
    rst    = 1'b0;
    mon_en = 1'b1;

    // Eight sequential words, ack three cycles after the request.
    ack_min = 3; ack_max = 3;
    for (int i = 1; i <= 8; i++) push(128'(i), 1'b1);
    wait_drain("drain_first", 200);

    // Seven words never trigger a request; the eighth does one cycle later.
    ack_min = 0; ack_max = 0;
    for (int i = 0; i < 7; i++) push(rand_word(), 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (wr_req) seen = 1'b1;
    end
    check("req_below_burst", 128'(seen), 128'(0));
    push(rand_word(), 1'b1);
    check("req_latency_early", 128'(wr_req), 128'(0));
    idle(1);
    check("req_latency", 128'(wr_req), 128'(1));
    wait_drain("drain_latency", 200);

    // Full FIFO with a pop in every push cycle: nothing is dropped.
    ack_en = 1'b0;
    for (int i = 0; i < 32; i++) push(rand_word(), 1'b1);
    idle(2);
    ack_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (wr_ack) break;
    end
    check("full_ack_seen", 128'(wr_ack), 128'(1));
    for (int i = 0; i < 8; i++) push(rand_word(), 1'b1);
    check("full_pop_no_ovf", 128'(overflow), 128'(0));
    wait_drain("drain_full_pop", 400);
    check("full_pop_no_ovf_end", 128'(overflow), 128'(0));

    // Overflow: 33rd word dropped while the controller stalls.
    ack_en = 1'b0;
    for (int i = 0; i < 32; i++) push(rand_word(), 1'b1);
    check("ovf_before", 128'(overflow), 128'(0));
    push(rand_word(), 1'b0);
    check("ovf_set", 128'(overflow), 128'(1));
`ifdef HDR_FRAME_WRITER_DROP_CNT_EN
    check("drop_cnt", 128'(drop_cnt), 128'(1));
`endif
    ack_en = 1'b1;
    wait_drain("drain_ovf", 400);
    check("ovf_sticky", 128'(overflow), 128'(1));

    // Reset on the fourth beat of a burst.
    ack_min = 0; ack_max = 0;
    for (int i = 0; i < 8; i++) push(rand_word(), 1'b1);
    for (int i = 0; i < 50; i++) begin
      if (wr_data_valid) break;
      idle(1);
    end
    check("beat_start_seen", 128'(wr_data_valid), 128'(1));
    idle(3);
    rst    = 1'b1;
    mon_en = 1'b0;
    idle(1);
    check("mid_rst_valid",    128'(wr_data_valid), 128'(0));
    check("mid_rst_req",      128'(wr_req),        128'(0));
    check("mid_rst_buf_sel",  128'(buf_sel),       128'(0));
    check("mid_rst_wr_addr",  128'(wr_addr),       128'(BUF0));
    check("mid_rst_overflow", 128'(overflow),      128'(0));
    rst = 1'b0;
    exp_q.delete();
    pushed     = 0;
    beats_seen = 0;
    m_word     = 0;
    m_buf      = 1'b0;
    mon_en     = 1'b1;
    for (int i = 0; i < 7; i++) push(rand_word(), 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (wr_req) seen = 1'b1;
    end
    check("mid_rst_fifo_empty", 128'(seen), 128'(0));
    push(rand_word(), 1'b1);
    wait_drain("drain_after_rst", 200);

    // Complete a frame (8 words already written), then start the next one.
    stream(FRAME_W - 8, 7);
    wait_drain("drain_frame", 400);
    check("frame_pulses", 128'(fw_count), 128'(1));
    check("frame_buf_sel", 128'(buf_sel), 128'(1));
    for (int i = 0; i < 8; i++) push(rand_word(), 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (wr_req) break;
      idle(1);
    end
    check("next_frame_addr", 128'(wr_addr), 128'(BUF1));
    wait_drain("drain_next_frame", 200);

    // Random traffic with random acknowledge latency.
    ack_min = 0; ack_max = 3;
    stream(200, 4);
    wait_drain("drain_random", 600);
    check("random_no_ovf", 128'(overflow), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
